// File: rtl/sdp_pipe_unit.sv
// sdp_pipe_unit: three-stage pipelined 8-bit datapath with valid/ready handshakes.
//   t = ctl_a ? a + b : a - b;  r = ctl_b ? (t * c) : (t ^ c), all modulo 2^WIDTH.
//   Stage 1 holds t/c/ctl_b, stage 2 holds r, stage 3 is the output register.
//   The whole pipe advances together; bubbles are not collapsed.
// Optional build macro: SDP_PIPE_STATS_EN enables the accepted/emitted counters.
//   Without it, o_acc_cnt and o_emit_cnt are tied to zero and no counters exist.

module sdp_pipe_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_ctl_a,
    input  logic             i_ctl_b,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [CNT_W-1:0] o_acc_cnt,
    output logic [CNT_W-1:0] o_emit_cnt
);

    // Stage 1
    logic             r_v1;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_c1;
    logic             r_ctl_b1;
    // Stage 2
    logic             r_v2;
    logic [WIDTH-1:0] r_r;
    // Stage 3 (output register)
    logic             r_v3;
    logic [WIDTH-1:0] r_out;

    logic             w_adv;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_mul;
    logic [WIDTH-1:0] w_r;

    // Global advance: the pipe moves whenever the output slot is empty or being drained.
    always_comb begin
        w_adv = !r_v3 || i_out_ready;
    end

    // Stage-1 combinational op: add or subtract, wrapping at WIDTH bits.
    always_comb begin
        w_t = i_ctl_a ? (i_a + i_b) : (i_a - i_b);
    end

    // Stage-2 combinational op: low half of the product, or XOR.
    always_comb begin
        w_mul = r_t * r_c1;
        w_r   = r_ctl_b1 ? w_mul : (r_t ^ r_c1);
    end

    // Pipeline registers: reset clears everything, otherwise all stages shift together on adv.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1     <= 1'b0;
            r_t      <= '0;
            r_c1     <= '0;
            r_ctl_b1 <= 1'b0;
            r_v2     <= 1'b0;
            r_r      <= '0;
            r_v3     <= 1'b0;
            r_out    <= '0;
        end else if (w_adv) begin
            r_v1     <= i_in_valid;
            r_t      <= w_t;
            r_c1     <= i_c;
            r_ctl_b1 <= i_ctl_b;
            r_v2     <= r_v1;
            r_r      <= w_r;
            r_v3     <= r_v2;
            r_out    <= r_r;
        end
    end

    // Handshake and result outputs.
    always_comb begin
        o_in_ready  = w_adv;
        o_out_valid = r_v3;
        o_out_data  = r_out;
    end

`ifdef SDP_PIPE_STATS_EN
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_emit_cnt;
    logic             w_accept;
    logic             w_emit;

    // Handshake events seen by the statistics counters.
    always_comb begin
        w_accept = i_in_valid && w_adv;
        w_emit   = r_v3 && i_out_ready;
    end

    // Free-running wrap-around counters of accepted and emitted transactions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_cnt  <= '0;
            r_emit_cnt <= '0;
        end else begin
            if (w_accept) r_acc_cnt <= r_acc_cnt + 1'b1;
            if (w_emit)   r_emit_cnt <= r_emit_cnt + 1'b1;
        end
    end

    // Counter outputs.
    always_comb begin
        o_acc_cnt  = r_acc_cnt;
        o_emit_cnt = r_emit_cnt;
    end
`else
    // Statistics disabled: counters read as constant zero.
    always_comb begin
        o_acc_cnt  = '0;
        o_emit_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_sdp_pipe_unit.sv
// Testbench for sdp_pipe_unit: random and directed stimulus, scoreboard queue of
// expected results filled on acceptance and drained by a monitor on emission.
// Counter checks follow SDP_PIPE_STATS_EN when it is defined for the bench too.

module tb_sdp_pipe_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        ctl_a;
    logic        ctl_b;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] acc_cnt;
    logic [15:0] emit_cnt;

    sdp_pipe_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_ctl_a     (ctl_a),
        .i_ctl_b     (ctl_b),
        .i_a         (a),
        .i_b         (b),
        .i_c         (c),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_acc_cnt   (acc_cnt),
        .o_emit_cnt  (emit_cnt)
    );

    typedef struct {
        logic [7:0] d;
        int         e;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          lat_chk = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    logic [15:0] m_acc = '0;
    logic [15:0] m_emit = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference function from plain integer arithmetic modulo 256.
    function automatic logic [7:0] ref_fn(input bit ca, input bit cb, input int ia, input int ib,
                                          input int ic);
        int t;
        int r;
        t = ca ? (ia + ib) % 256 : (ia - ib + 256) % 256;
        r = cb ? (t * ic) % 256 : (t ^ ic);
        return r[7:0];
    endfunction

    // Monitor and scoreboard: everything sampled at the falling edge, mid-cycle.
    always @(negedge clk) begin
        exp_t x;
`ifdef SDP_PIPE_STATS_EN
        check("acc_cnt", acc_cnt, m_acc);
        check("emit_cnt", emit_cnt, m_emit);
`else
        if (cyc % 16 == 0) begin
            check("acc_cnt_zero", acc_cnt, 0);
            check("emit_cnt_zero", emit_cnt, 0);
        end
`endif
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
        end
        if (reset) begin
            sb_q.delete();
            m_acc      = '0;
            m_emit     = '0;
            prev_stall = 0;
        end else begin
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL emit_unexpected got=%0h exp=none (cycle %0d)", out_data, cyc);
                end else begin
                    x = sb_q.pop_front();
                    check("out_data", out_data, x.d);
                    if (lat_chk) check("latency", cyc - x.e, 2);
                end
                m_emit = m_emit + 1'b1;
            end
            if (in_valid && in_ready) begin
                x.d = ref_fn(ctl_a, ctl_b, a, b, c);
                x.e = cyc + 1;
                sb_q.push_back(x);
                m_acc = m_acc + 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic idle_inputs();
        in_valid = 1'b0;
        ctl_a    = 1'($urandom);
        ctl_b    = 1'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
        c        = 8'($urandom);
    endtask

    // Present one transaction and hold it until accepted (bounded).
    task automatic send(input bit ca, input bit cb, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ic);
        int n;
        in_valid = 1'b1;
        ctl_a    = ca;
        ctl_b    = cb;
        a        = ia;
        b        = ib;
        c        = ic;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_acc_cnt", acc_cnt, 0);
        check("rst_emit_cnt", emit_cnt, 0);
        @(posedge clk);
        #1;

        // Single transaction with explicit 3-cycle latency
        lat_chk = 1;
        send(1'b1, 1'b0, 8'h10, 8'h05, 8'h0F);
        @(negedge clk);
        check("single_pre_valid0", out_valid, 0);
        @(negedge clk);
        check("single_pre_valid1", out_valid, 0);
        @(negedge clk);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'h1A);
        @(posedge clk);
        #1;
        wait_drain();

        // Wrap arithmetic
        send(1'b0, 1'b1, 8'h03, 8'h05, 8'h03);
        send(1'b1, 1'b1, 8'hFF, 8'h02, 8'h80);
        wait_drain();

        // Streaming: 10 back-to-back from a clean reset
        do_reset();
        for (int i = 0; i < 10; i++)
            send(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        wait_drain();
`ifdef SDP_PIPE_STATS_EN
        check("stream_acc_cnt", acc_cnt, 10);
        check("stream_emit_cnt", emit_cnt, 10);
`endif

        // Backpressure: fill 3, hold 5 cycles, then drain on consecutive cycles
        lat_chk   = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_depth", sb_q.size(), 3);
`ifdef SDP_PIPE_STATS_EN
            check("bp_cnt_diff", 16'(acc_cnt - emit_cnt), 3);
`endif
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_drain_valid", out_valid, 1);
        end
        @(negedge clk);
        check("bp_drain_done", out_valid, 0);
        @(posedge clk);
        #1;
        wait_drain();

        // Reset with two transactions in flight
        lat_chk = 1;
        send(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        send(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_out_valid", out_valid, 0);
            check("midrst_out_data", out_data, 0);
        end
        @(posedge clk);
        #1;
        send(1'b0, 1'b1, 8'h03, 8'h05, 8'h03);
        wait_drain();

        // Random traffic with random backpressure
        lat_chk = 0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            idle_inputs();
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        out_ready = 1'b1;
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
